imem_ctrl: RTL and testbench

Controller that owns the single-port synchronous instruction RAM of the risc16 core.
After reset it runs a boot phase that streams a program image into the RAM from a loader interface, holding the CPU stalled. It then releases the CPU and arbitrates each cycle between CPU instruction fetch and loader patch writes, with a starvation guard for the loader.
Sits between the fetch stage (PC/instruction), the program loader and the RAM macro.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_arb.sv | 36 +++
 rtl/imem_ctrl.sv | 108 ++++++++++
 tb/tb_imem_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, default widths and address helper for the instruction RAM controller
package imem_pkg;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 16;

   // Byte PC to word index; callers truncate to their RAM address width.
   function automatic logic [15:0] word_addr(input logic [15:0] pc);
      return pc >> 1;
   endfunction

endpackage

// File: rtl/imem_arb.sv
// rtl/imem_arb.sv - run-phase fetch/loader arbiter with loader starvation guard
module imem_arb
#(
   parameter int STARVE_MAX = 4
)
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic fetch_req,
   input  logic ld_valid,
   output logic grant_fetch,
   output logic grant_ld
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_cnt;
   logic             starved;

   assign starved     = (starve_cnt == CNT_W'(STARVE_MAX));
   assign grant_fetch = en && fetch_req && !(ld_valid && starved);
   assign grant_ld    = en && ld_valid && !grant_fetch;

   // Counts consecutive denied loader cycles; any gap in ld_valid restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!en || !ld_valid || grant_ld) begin
         starve_cnt <= '0;
      end else if (!starved) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - instruction RAM owner: boot-time image load, then fetch/patch arbitration
module imem_ctrl
   import imem_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int BOOT_WORDS = 15,
   parameter int STARVE_MAX = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [15:0]       fetch_pc,
   output logic [DATA_W-1:0] fetch_instr,
   output logic              fetch_valid,
   output logic              cpu_stall,
   output logic              boot_done,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] BOOT_LAST = ADDR_W'(BOOT_WORDS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] boot_cnt_q, boot_cnt_d;
   logic [ADDR_W-1:0] last_addr_q;
   logic [ADDR_W-1:0] fetch_waddr;
   logic              fetch_valid_q;
   logic              run;
   logic              grant_fetch, grant_ld;

   assign run         = (state_q == ST_RUN);
   assign fetch_waddr = ADDR_W'(word_addr(fetch_pc));
   assign boot_done   = run;
   assign fetch_valid = fetch_valid_q;
   assign fetch_instr = mem_rdata;

   imem_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .en          (run),
      .fetch_req   (fetch_req),
      .ld_valid    (ld_valid),
      .grant_fetch (grant_fetch),
      .grant_ld    (grant_ld)
   );

   // Outputs are gated by rst so an asynchronous reset silences the RAM port at once.
   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      ld_ready   = 1'b0;
      cpu_stall  = 1'b1;
      mem_we     = 1'b0;
      mem_addr   = last_addr_q;
      mem_wdata  = '0;
      if (!rst) begin
         case (state_q)
            ST_BOOT: begin
               ld_ready = 1'b1;
               if (ld_valid) begin
                  mem_we     = 1'b1;
                  mem_addr   = boot_cnt_q;
                  mem_wdata  = ld_data;
                  boot_cnt_d = boot_cnt_q + 1'b1;
                  if (boot_cnt_q == BOOT_LAST) begin
                     state_d = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               ld_ready  = grant_ld;
               cpu_stall = fetch_req && !grant_fetch;
               if (grant_fetch) begin
                  mem_addr = fetch_waddr;
               end else if (grant_ld) begin
                  mem_we    = 1'b1;
                  mem_addr  = ld_addr;
                  mem_wdata = ld_data;
               end
            end
            default: state_d = ST_BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_BOOT;
         boot_cnt_q    <= '0;
         last_addr_q   <= '0;
         fetch_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         boot_cnt_q    <= boot_cnt_d;
         last_addr_q   <= mem_addr;
         fetch_valid_q <= grant_fetch;
      end
   end

endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - directed table-driven bench for imem_ctrl with a behavioural sync RAM
module tb_imem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic [15:0] fetch_pc;
   logic [15:0] fetch_instr;
   logic        fetch_valid;
   logic        cpu_stall;
   logic        boot_done;
   logic        ld_valid;
   logic [3:0]  ld_addr;
   logic [15:0] ld_data;
   logic        ld_ready;
   logic        mem_we;
   logic [3:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   logic [15:0] ram [16];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        freq;
      logic [15:0] pc;
      logic        lv;
      logic [3:0]  la;
      logic [15:0] ld;
      logic        we;
      logic [3:0]  addr;
      logic        stall;
      logic        rdy;
      logic        fv;
      logic [15:0] instr;
   } vec_t;

   vec_t vt [23];

   always #5 clk = ~clk;

   imem_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .fetch_pc    (fetch_pc),
      .fetch_instr (fetch_instr),
      .fetch_valid (fetch_valid),
      .cpu_stall   (cpu_stall),
      .boot_done   (boot_done),
      .ld_valid    (ld_valid),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 16'h0000;
      mem_rdata = 16'h0000;
   end

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " mem_we"},      32'(mem_we),      32'd0);
      chk({tag, " mem_addr"},    32'(mem_addr),    32'd0);
      chk({tag, " mem_wdata"},   32'(mem_wdata),   32'd0);
      chk({tag, " ld_ready"},    32'(ld_ready),    32'd0);
      chk({tag, " cpu_stall"},   32'(cpu_stall),   32'd1);
      chk({tag, " boot_done"},   32'(boot_done),   32'd0);
      chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'd0);
   endtask

   // Drives n boot beats with fetch_req held high; leaves time at posedge+1 after the last beat.
   task automatic do_boot(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         fetch_req = 1'b1;
         fetch_pc  = 16'h0004;
         ld_valid  = 1'b1;
         ld_addr   = 4'h9;
         ld_data   = base + 16'(i);
         @(negedge clk);
         chk($sformatf("boot%0d mem_we", i),      32'(mem_we),      32'd1);
         chk($sformatf("boot%0d mem_addr", i),    32'(mem_addr),    32'(i));
         chk($sformatf("boot%0d mem_wdata", i),   32'(mem_wdata),   32'(base + 16'(i)));
         chk($sformatf("boot%0d ld_ready", i),    32'(ld_ready),    32'd1);
         chk($sformatf("boot%0d cpu_stall", i),   32'(cpu_stall),   32'd1);
         chk($sformatf("boot%0d fetch_valid", i), 32'(fetch_valid), 32'd0);
         chk($sformatf("boot%0d boot_done", i),   32'(boot_done),   32'd0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      vt[0]  = '{1'b1, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000};
      vt[1]  = '{1'b1, 16'h0002, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 16'h1000};
      vt[2]  = '{1'b1, 16'h0004, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 16'h1001};
      vt[3]  = '{1'b1, 16'h0003, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 16'h1002};
      vt[4]  = '{1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 16'h1001};
      vt[5]  = '{1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 16'h0000};
      vt[6]  = '{1'b1, 16'h000A, 1'b1, 4'h3, 16'hBEEF, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 16'h0000};
      vt[7]  = '{1'b1, 16'h000A, 1'b1, 4'h3, 16'hBEEF, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 16'h1005};
      vt[8]  = '{1'b1, 16'h000A, 1'b1, 4'h3, 16'hBEEF, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 16'h1005};
      vt[9]  = '{1'b1, 16'h000A, 1'b1, 4'h3, 16'hBEEF, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 16'h1005};
      vt[10] = '{1'b1, 16'h000A, 1'b1, 4'h3, 16'hBEEF, 1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 16'h1005};
      vt[11] = '{1'b1, 16'h0006, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 16'h0000};
      vt[12] = '{1'b1, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'hBEEF};
      vt[13] = '{1'b0, 16'h0000, 1'b1, 4'h7, 16'h7777, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 16'h1000};
      vt[14] = '{1'b1, 16'h000E, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 16'h0000};
      vt[15] = '{1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1, 16'h7777};
      vt[16] = '{1'b1, 16'h0002, 1'b1, 4'h9, 16'h9999, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 16'h0000};
      vt[17] = '{1'b1, 16'h0002, 1'b1, 4'h9, 16'h9999, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 16'h1001};
      vt[18] = '{1'b1, 16'h0002, 1'b1, 4'h9, 16'h9999, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 16'h1001};
      vt[19] = '{1'b1, 16'h0002, 1'b0, 4'h9, 16'h9999, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 16'h1001};
      vt[20] = '{1'b1, 16'h0002, 1'b1, 4'h9, 16'h9999, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 16'h1001};
      vt[21] = '{1'b1, 16'h0002, 1'b1, 4'h9, 16'h9999, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 16'h1001};
      vt[22] = '{1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 16'h1001};

      rst       = 1'b1;
      fetch_req = 1'b1;
      fetch_pc  = 16'h0004;
      ld_valid  = 1'b1;
      ld_addr   = 4'h9;
      ld_data   = 16'h5555;
      #2;
      chk_reset_outputs("por");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Partial boot, then asynchronous reset between clock edges.
      do_boot(6, 16'h2000);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("midboot_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      do_boot(15, 16'h1000);

      for (int k = 0; k < 23; k++) begin
         fetch_req = vt[k].freq;
         fetch_pc  = vt[k].pc;
         ld_valid  = vt[k].lv;
         ld_addr   = vt[k].la;
         ld_data   = vt[k].ld;
         @(negedge clk);
         chk($sformatf("v%0d boot_done", k),   32'(boot_done),   32'd1);
         chk($sformatf("v%0d mem_we", k),      32'(mem_we),      32'(vt[k].we));
         chk($sformatf("v%0d mem_addr", k),    32'(mem_addr),    32'(vt[k].addr));
         chk($sformatf("v%0d cpu_stall", k),   32'(cpu_stall),   32'(vt[k].stall));
         chk($sformatf("v%0d ld_ready", k),    32'(ld_ready),    32'(vt[k].rdy));
         chk($sformatf("v%0d fetch_valid", k), 32'(fetch_valid), 32'(vt[k].fv));
         if (vt[k].we)
            chk($sformatf("v%0d mem_wdata", k), 32'(mem_wdata), 32'(vt[k].ld));
         if (vt[k].fv)
            chk($sformatf("v%0d fetch_instr", k), 32'(fetch_instr), 32'(vt[k].instr));
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
